// File: rtl/nibble_mult_seq_if.sv
// Start/done handshake and operand/result bus between a requester and the nibble multiplier sequencer.
interface nibble_mult_seq_if #(
  parameter int NIB_W = 4
);
  logic                 start;
  logic [2*NIB_W-1:0]   dataa;
  logic [2*NIB_W-1:0]   datab;
  logic [1:0]           nib_sel;
  logic                 busy;
  logic                 done;
  logic [4*NIB_W-1:0]   product;

  modport master (
    output start, dataa, datab,
    input  nib_sel, busy, done, product
  );

  modport slave (
    input  start, dataa, datab,
    output nib_sel, busy, done, product
  );
endinterface

// File: rtl/nibble_mult_seq.sv
// 8x8 multiply from four 4x4 partial products, one per cycle; done pulses 5 cycles after start is seen.
// One multiply in flight: start is ignored outside IDLE, so the requester simply holds or re-pulses it.
module nibble_mult_seq #(
  parameter int NIB_W       = 4,
  parameter bit CLEAR_ON_GO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  nibble_mult_seq_if.slave  bus
);
  localparam int OP_W   = 2 * NIB_W;
  localparam int PROD_W = 4 * NIB_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state;
  logic [1:0]          step;
  logic [OP_W-1:0]     op_a;
  logic [OP_W-1:0]     op_b;
  logic [PROD_W-1:0]   acc;
  logic [PROD_W-1:0]   product_q;
  logic [1:0]          nib_sel_q;
  logic                busy_q;
  logic                done_q;

  logic [NIB_W-1:0]    nib_x;
  logic [NIB_W-1:0]    nib_y;
  logic [OP_W-1:0]     pp;
  logic [PROD_W-1:0]   pp_ext;
  logic [PROD_W-1:0]   pp_sh;
  logic [PROD_W-1:0]   acc_next;

  always_comb begin
    nib_x  = '0;
    nib_y  = '0;
    pp     = '0;
    pp_ext = '0;
    pp_sh  = '0;
    unique case (step)
      2'd0: begin nib_x = op_a[NIB_W-1:0];    nib_y = op_b[NIB_W-1:0];    end
      2'd1: begin nib_x = op_a[NIB_W-1:0];    nib_y = op_b[OP_W-1:NIB_W]; end
      2'd2: begin nib_x = op_a[OP_W-1:NIB_W]; nib_y = op_b[NIB_W-1:0];    end
      default: begin nib_x = op_a[OP_W-1:NIB_W]; nib_y = op_b[OP_W-1:NIB_W]; end
    endcase
    pp     = {{NIB_W{1'b0}}, nib_x} * {{NIB_W{1'b0}}, nib_y};
    pp_ext = {{OP_W{1'b0}}, pp};
    unique case (step)
      2'd0:    pp_sh = pp_ext;
      2'd1,
      2'd2:    pp_sh = pp_ext << NIB_W;
      default: pp_sh = pp_ext << (2 * NIB_W);
    endcase
    acc_next = acc + pp_sh;
  end

  // Handshake outputs are registered from the state, so they trail it by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      step      <= 2'd0;
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      product_q <= '0;
      nib_sel_q <= 2'd0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      busy_q    <= (state == CALC);
      nib_sel_q <= (state == CALC) ? step : 2'd0;
      done_q    <= (state == DONE);
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            op_a  <= bus.dataa;
            op_b  <= bus.datab;
            acc   <= '0;
            step  <= 2'd0;
            state <= CALC;
            if (CLEAR_ON_GO) product_q <= '0;
          end
        end
        CALC: begin
          acc <= acc_next;
          if (step == 2'd3) begin
            product_q <= acc_next;
            step      <= 2'd0;
            state     <= DONE;
          end else begin
            step <= step + 2'd1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.product = product_q;
  assign bus.nib_sel = nib_sel_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
endmodule

// File: tb/tb_nibble_mult_seq.sv
// Directed table plus hand sequences and random operands for the nibble multiplier sequencer.
module tb_nibble_mult_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [15:0] prev_prod;

  nibble_mult_seq_if #(.NIB_W(4)) bus();

  nibble_mult_seq #(.NIB_W(4), .CLEAR_ON_GO(1'b0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Start at negedge, seen at edge N; observe negedges after N+1..N+5.
  task automatic run_mult(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp,
                          input string tag);
    @(negedge clk);
    bus.dataa = a;
    bus.datab = b;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dataa = ~a;
    bus.datab = ~b;
    check({tag, " done_k0"}, 32'(bus.done), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        check($sformatf("%s busy_k%0d", tag, k), 32'(bus.busy), 32'd1);
        check($sformatf("%s nib_sel_k%0d", tag, k), 32'(bus.nib_sel), 32'(k - 1));
        check($sformatf("%s done_k%0d", tag, k), 32'(bus.done), 32'd0);
        if (k <= 3)
          check($sformatf("%s held_prod_k%0d", tag, k), 32'(bus.product), 32'(prev_prod));
      end else begin
        check({tag, " done_k5"}, 32'(bus.done), 32'd1);
        check({tag, " busy_k5"}, 32'(bus.busy), 32'd0);
        check({tag, " product"}, 32'(bus.product), 32'(exp));
      end
    end
    prev_prod = exp;
  endtask

  initial begin
    int busy_cnt;
    int done_cnt;
    logic [7:0] ra;
    logic [7:0] rb;
    vec_t held[3];

    checks    = 0;
    errors    = 0;
    prev_prod = 16'h0000;

    vecs[0] = '{8'h12, 8'h34, 16'h03A8};
    vecs[1] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[2] = '{8'h00, 8'hA5, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h0F, 8'h0F, 16'h00E1};
    vecs[5] = '{8'hF0, 8'h0F, 16'h0E10};
    vecs[6] = '{8'h10, 8'h10, 16'h0100};
    vecs[7] = '{8'hAB, 8'hCD, 16'h88EF};
    vecs[8] = '{8'h07, 8'h09, 16'h003F};

    bus.start = 1'b0;
    bus.dataa = 8'h00;
    bus.datab = 8'h00;
    reset     = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", 32'(bus.busy), 32'd0);
    check("rst done", 32'(bus.done), 32'd0);
    check("rst nib_sel", 32'(bus.nib_sel), 32'd0);
    check("rst product", 32'(bus.product), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 9; i++)
      run_mult(vecs[i].a, vecs[i].b, vecs[i].p, $sformatf("vec%0d", i));

    // Second start pulsed while nib_sel shows 2 must be ignored.
    @(negedge clk);
    bus.dataa = 8'h12;
    bus.datab = 8'h34;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    busy_cnt  = 32'(bus.busy);
    done_cnt  = 0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      busy_cnt += 32'(bus.busy);
      if (k == 3) begin
        check("ign nib_sel_at_start", 32'(bus.nib_sel), 32'd2);
        bus.dataa = 8'hFF;
        bus.datab = 8'hFF;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.done) begin
        done_cnt++;
        check("ign product", 32'(bus.product), 32'h03A8);
      end
    end
    check("ign busy_cycles", 32'(busy_cnt), 32'd4);
    check("ign done_pulses", 32'(done_cnt), 32'd1);
    prev_prod = 16'h03A8;

    // Reset at step 2 abandons the multiply.
    @(negedge clk);
    bus.dataa = 8'h80;
    bus.datab = 8'h02;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rstmid nib_sel_before", 32'(bus.nib_sel), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("rstmid busy", 32'(bus.busy), 32'd0);
    check("rstmid nib_sel", 32'(bus.nib_sel), 32'd0);
    check("rstmid product", 32'(bus.product), 32'd0);
    check("rstmid done", 32'(bus.done), 32'd0);
    reset    = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      done_cnt += 32'(bus.done);
    end
    check("rstmid no_done", 32'(done_cnt), 32'd0);
    prev_prod = 16'h0000;
    run_mult(8'h12, 8'h34, 16'h03A8, "post_rst");

    // start held high: accepts every 6 cycles, operands swapped in during CALC.
    held[0] = '{8'h12, 8'h34, 16'h03A8};
    held[1] = '{8'hFF, 8'hFF, 16'hFE01};
    held[2] = '{8'h80, 8'h02, 16'h0100};
    @(negedge clk);
    bus.dataa = held[0].a;
    bus.datab = held[0].b;
    bus.start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("held%0d done_k0", i), 32'(bus.done), 32'd0);
      if (i < 2) begin
        bus.dataa = held[i+1].a;
        bus.datab = held[i+1].b;
      end else begin
        bus.start = 1'b0;
      end
      for (int k = 1; k <= 5; k++) begin
        @(negedge clk);
        if (k < 5) begin
          check($sformatf("held%0d done_k%0d", i, k), 32'(bus.done), 32'd0);
        end else begin
          check($sformatf("held%0d done", i), 32'(bus.done), 32'd1);
          check($sformatf("held%0d product", i), 32'(bus.product), 32'(held[i].p));
        end
      end
    end
    prev_prod = held[2].p;

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      run_mult(ra, rb, 16'(ra) * 16'(rb), $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
